// File: rtl/axi4_lite_master_itf.sv
// AXI4-Lite single-outstanding master: one command in, one AXI transaction out.
// Optional watchdog: define AXI4_LITE_MASTER_TIMEOUT_EN to abort stalled transfers.
module axi4_lite_master_itf #(
  parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int G_TIMEOUT_CYCLES       = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_rnw,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                                rsp_valid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                awvalid,
  output logic [G_AXI4_LITE_ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]                          awprot,
  input  logic                                awready,
  output logic                                wvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]   wdata,
  output logic [G_AXI4_LITE_DATA_WIDTH/8-1:0] wstrb,
  input  logic                                wready,
  output logic                                bready,
  input  logic                                bvalid,
  input  logic [1:0]                          bresp,
  output logic                                arvalid,
  output logic [G_AXI4_LITE_ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]                          arprot,
  input  logic                                arready,
  output logic                                rready,
  input  logic                                rvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                          rresp
);

  if (G_AXI4_LITE_DATA_WIDTH != 32 &&
      G_AXI4_LITE_DATA_WIDTH != 64) begin : g_bad_dw
    $error("data width must be 32 or 64");
  end
  if (G_TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("timeout must be at least 2 cycles");
  end

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RD, RDATA
  } state_t;

  state_t state;

  assign cmd_ready = (state == IDLE);
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wstrb     = '1;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(G_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(G_TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      araddr    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_rnw) begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD;
            end else begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR;
            end
          end
        end
        WR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          // both channels are done once each has handshaken now or earlier
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid && bready) begin
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= bresp;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        RD: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid && rready) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      // watchdog overrides whatever the FSM decided this cycle
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        awvalid   <= 1'b0;
        wvalid    <= 1'b0;
        bready    <= 1'b0;
        arvalid   <= 1'b0;
        rready    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_resp  <= 2'b11;
        rsp_rdata <= '0;
        state     <= IDLE;
      end else begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_itf.sv
// Bench for axi4_lite_master_itf: randomized AXI slave with delays,
// reference memory model and per-cycle response/protocol checker.
module tb_axi4_lite_master_itf;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready, wvalid, wready, bready, bvalid;
  logic [AW-1:0] awaddr;
  logic [2:0] awprot, arprot;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic arvalid, arready, rready, rvalid;
  logic [AW-1:0] araddr;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  axi4_lite_master_itf #(
    .G_AXI4_LITE_ADDR_WIDTH(AW),
    .G_AXI4_LITE_DATA_WIDTH(DW),
    .G_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot),
    .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bready(bready), .bvalid(bvalid), .bresp(bresp),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot),
    .arready(arready),
    .rready(rready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [DW-1:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t exp_q[$];
  logic [1:0] plan_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_pend, w_pend, b_pend, ar_pend, r_pend;
  bit aw_done, w_done, ar_done;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;

  task automatic set_dly(input int a, input int w, input int b,
                         input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0;
        arready = 0; rvalid = 0;
        {aw_pend, w_pend, b_pend, ar_pend, r_pend} = '0;
        {aw_done, w_done, ar_done} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        continue;
      end
      if (aw_pend) begin awready = 0; aw_pend = 0; aw_done = 1; end
      if (w_pend) begin wready = 0; w_pend = 0; w_done = 1; end
      if (ar_pend) begin arready = 0; ar_pend = 0; ar_done = 1; end
      if (b_pend) begin
        bvalid = 0; b_pend = 0; aw_done = 0; w_done = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end
      if (r_pend) begin
        rvalid = 0; r_pend = 0; ar_done = 0; ar_cnt = 0; r_cnt = 0;
      end
      if (awvalid && !aw_done && !awready) begin
        if (aw_cnt >= aw_dly) begin
          awready = 1; s_awaddr = awaddr; aw_pend = 1;
        end else aw_cnt++;
      end
      if (wvalid && !w_done && !wready) begin
        if (w_cnt >= w_dly) begin
          wready = 1; s_wdata = wdata; w_pend = 1;
        end else w_cnt++;
      end
      if (arvalid && !ar_done && !arready) begin
        if (ar_cnt >= ar_dly) begin
          arready = 1; s_araddr = araddr; ar_pend = 1;
        end else ar_cnt++;
      end
      if (aw_done && w_done && !bvalid) begin
        if (b_cnt >= b_dly) begin
          bresp = (plan_q.size() != 0) ? plan_q.pop_front() : 2'b00;
          bvalid = 1;
          if (bresp == 2'b00) slv_mem[s_awaddr] = s_wdata;
        end else b_cnt++;
      end
      if (bvalid && bready) b_pend = 1;
      if (ar_done && !rvalid) begin
        if (r_cnt >= r_dly) begin
          rresp = (plan_q.size() != 0) ? plan_q.pop_front() : 2'b00;
          rdata = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : '0;
          rvalid = 1;
        end else r_cnt++;
      end
      if (rvalid && rready) r_pend = 1;
    end
  end

  // ---------------- monitor ----------------
  bit p_aw, p_w, p_ar;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;

  initial begin
    exp_t e;
    bit abort;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        p_aw = 0; p_w = 0; p_ar = 0;
        continue;
      end
      abort = rsp_valid && (rsp_resp == 2'b11);
      if (p_aw && !abort)
        check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w && !abort)
        check("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
      if (p_ar && !abort)
        check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata  = wdata;
      p_ar = arvalid && !arready; p_araddr = araddr;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
          last_rdata = rsp_rdata;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit rnw, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [1:0] resp);
    int n = 0;
    exp_t e;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    check("issue_wait", cmd_ready, 1'b1);
    cmd_valid = 1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd;
    acc_cyc = cyc;
    if (rnw) begin
      e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : '0;
    end else begin
      e.rdata = '0;
      if (resp == 2'b00) ref_mem[addr] = wd;
    end
    e.resp = resp;
    exp_q.push_back(e);
    plan_q.push_back(resp);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("wait_idle", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"},
          {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid},
          7'b1000000);
    check({tag, "_addr"}, {awaddr, araddr}, 64'h0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_rsp"}, {rsp_rdata, rsp_resp}, 0);
  endtask

  initial begin
    int t0;
    cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_wdata = 0;
    set_dly(0, 0, 0, 0, 0);
    rst = 1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 0;
    @(negedge clk);

    // zero-wait write then read-back
    issue(0, 32'h4, 32'hDEADBEEF, 2'b00);
    t0 = acc_cyc;
    check("zw_c1_valids", {awvalid, wvalid}, 2'b11);
    check("zw_c1_awaddr", awaddr, 32'h4);
    check("zw_c1_wdata", wdata, 32'hDEADBEEF);
    check("zw_c1_fixed", {awprot, arprot, wstrb}, 10'h00F);
    @(negedge clk);
    check("zw_c2_bready", {bready, awvalid, wvalid}, 3'b100);
    @(negedge clk);
    check("zw_c3_rsp", {rsp_valid, cmd_ready, rsp_resp}, 4'b1100);
    issue(1, 32'h4, 0, 2'b00);
    check("b2b_gap", acc_cyc - t0, 3);
    check("zr_c1_ar", {arvalid, araddr}, {1'b1, 32'h4});
    @(negedge clk);
    check("zr_c2_rready", {rready, arvalid}, 2'b10);
    @(negedge clk);
    check("zr_c3_rsp", {rsp_valid, rsp_resp}, 3'b100);
    check("zr_c3_rdata", rsp_rdata, 32'hDEADBEEF);

    // slow awready, immediate wready
    set_dly(3, 0, 0, 0, 0);
    issue(0, 32'h10, 32'h12345678, 2'b00);
    check("aw3_c1", {awvalid, wvalid}, 2'b11);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("aw3_hold", {awvalid, wvalid, bready, awaddr},
            {3'b100, 32'h10});
    end
    @(negedge clk);
    check("aw3_c5", {awvalid, bready}, 2'b01);
    wait_idle();

    // error responses, busy cmd_valid pulses ignored
    set_dly(1, 2, 2, 2, 2);
    issue(0, 32'h20, 32'h0000A5A5, 2'b10);
    check("busy_wr_ready", cmd_ready, 1'b0);
    cmd_valid = 1; cmd_rnw = 1; cmd_addr = 32'h44;
    @(negedge clk);
    cmd_valid = 0;
    wait_idle();
    issue(1, 32'h20, 0, 2'b10);
    check("busy_rd_ready", cmd_ready, 1'b0);
    cmd_valid = 1; cmd_rnw = 0; cmd_addr = 32'h48;
    @(negedge clk);
    cmd_valid = 0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("no_extra_txn", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0);

    // reset while waiting for R
    set_dly(0, 0, 0, 0, 6);
    issue(1, 32'h4, 0, 2'b00);
    begin
      int n = 0;
      while (!rready && n < 50) begin @(negedge clk); n++; end
    end
    check("rdata_state", rready, 1'b1);
    #2 rst = 1;
    #1;
    check_reset("midrst");
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    check("midrst_no_rsp", rsp_valid, 1'b0);
    set_dly(0, 0, 0, 0, 0);
    issue(1, 32'h4, 0, 2'b00);
    wait_idle();
    check("post_rst_read", last_rdata, 32'hDEADBEEF);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit rnw;
      logic [AW-1:0] a;
      logic [1:0] rs;
      rnw = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 7)) << 2;
      rs = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      set_dly($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
      issue(rnw, a, $urandom, rs);
    end
    wait_idle();

    // stalled AR channel
    set_dly(0, 0, 0, 1000000, 0);
    issue(1, 32'h8, 0, 2'b00);
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    exp_q[0] = '{rdata: '0, resp: 2'b11};
    check("tmo_c1", {arvalid, rsp_valid}, 2'b10);
    for (int c = 2; c <= TMO; c++) begin
      @(negedge clk);
      check("tmo_hold", {arvalid, rsp_valid}, 2'b10);
    end
    @(negedge clk);
    check("tmo_rsp", {rsp_valid, arvalid, rready, rsp_resp}, 5'b10011);
    check("tmo_rdata", rsp_rdata, 0);
    @(negedge clk);
    check("tmo_idle", {cmd_ready, rsp_valid}, 2'b10);
`else
    for (int c = 1; c <= 40; c++) begin
      check("stall_hold", {arvalid, rsp_valid, araddr},
            {2'b10, 32'h8});
      @(negedge clk);
    end
`endif
    rst = 1;
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    check_reset("final_rst");
    rst = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
